// File: rtl/mario_sprite_gen.sv
// Mario screen pixel source: sky/ground background plus a 16x16 two-colour
// player sprite moved by buttons and a jump/gravity FSM updated once per frame.
// Ports: vga_clk, clrn (sync, active-low); row_addr/col_addr/rdn/vs from the
//   VGA controller; btn_left/btn_right/btn_jump async buttons;
//   d_out pixel colour (bbbb_gggg_rrrr); pos_x/pos_y sprite top-left;
//   airborne while in AIR; frame_tick one cycle after each frame update.
module mario_sprite_gen #(
    parameter int          SPR_W        = 16,
    parameter int          SPR_H        = 16,
    parameter int          GROUND_Y     = 400,
    parameter int          X_START      = 32,
    parameter int          X_MIN        = 0,
    parameter int          X_MAX        = 624,
    parameter int          STEP         = 2,
    parameter int          JUMP_V       = 8,
    parameter int          GRAVITY      = 1,
    parameter logic [11:0] SKY_COLOR    = 12'hE95,
    parameter logic [11:0] GROUND_COLOR = 12'h04A,
    parameter logic [11:0] HAT_COLOR    = 12'h00F,
    parameter logic [11:0] BODY_COLOR   = 12'hF00
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic        vs,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] d_out,
    output logic [9:0]  pos_x,
    output logic [8:0]  pos_y,
    output logic        airborne,
    output logic        frame_tick
);

    typedef enum logic {GROUND, AIR} state_t;

    localparam logic [8:0]         Y_REST   = 9'(GROUND_Y - SPR_H);
    localparam logic signed [10:0] Y_REST_S = 11'(GROUND_Y - SPR_H);

    state_t            state, state_nx;
    logic [1:0]        left_sync, right_sync;
    logic [2:0]        jump_sync;
    logic              vs_d, jump_req;
    logic              frame_upd, jump_rise;
    logic              go_left, go_right;
    logic signed [7:0] vel, vel_nx;
    logic [9:0]        pos_x_nx;
    logic [8:0]        pos_y_nx;
    logic [10:0]       x_ext;
    logic signed [10:0] ny;

    assign frame_upd = vs & ~vs_d;
    assign go_left   = left_sync[1];
    assign go_right  = right_sync[1];
    // jump_sync[2] is the previous synced level, used only for edge detection
    assign jump_rise = jump_sync[1] & ~jump_sync[2];
    assign airborne  = (state == AIR);

    always_ff @(posedge vga_clk) begin
        if (!clrn) begin
            left_sync  <= '0;
            right_sync <= '0;
            jump_sync  <= '0;
            vs_d       <= 1'b0;
            jump_req   <= 1'b0;
            frame_tick <= 1'b0;
            pos_x      <= 10'(X_START);
            pos_y      <= Y_REST;
            vel        <= '0;
            state      <= GROUND;
        end else begin
            left_sync  <= {left_sync[0], btn_left};
            right_sync <= {right_sync[0], btn_right};
            jump_sync  <= {jump_sync[1:0], btn_jump};
            vs_d       <= vs;
            frame_tick <= frame_upd;
            // a request not consumed by this frame is dropped, never buffered
            if (frame_upd)
                jump_req <= 1'b0;
            else if (jump_rise)
                jump_req <= 1'b1;
            if (frame_upd) begin
                pos_x <= pos_x_nx;
                pos_y <= pos_y_nx;
                vel   <= vel_nx;
                state <= state_nx;
            end
        end
    end

    // horizontal move, saturating at both edges
    always_comb begin
        x_ext    = {1'b0, pos_x};
        pos_x_nx = pos_x;
        if (go_right && !go_left) begin
            if (x_ext + 11'(STEP) > 11'(X_MAX))
                pos_x_nx = 10'(X_MAX);
            else
                pos_x_nx = pos_x + 10'(STEP);
        end else if (go_left && !go_right) begin
            if (x_ext < 11'(X_MIN + STEP))
                pos_x_nx = 10'(X_MIN);
            else
                pos_x_nx = pos_x - 10'(STEP);
        end
    end

    // vertical FSM; vel positive means moving up (row decreasing)
    always_comb begin
        ny       = $signed({2'b00, pos_y}) - $signed({{3{vel[7]}}, vel});
        state_nx = state;
        pos_y_nx = pos_y;
        vel_nx   = vel;
        unique case (state)
            GROUND: begin
                if (jump_req) begin
                    pos_y_nx = pos_y - 9'(JUMP_V);
                    vel_nx   = 8'(JUMP_V - GRAVITY);
                    state_nx = AIR;
                end
            end
            AIR: begin
                // landing wins over the ceiling clamp
                if (ny >= Y_REST_S) begin
                    pos_y_nx = Y_REST;
                    vel_nx   = '0;
                    state_nx = GROUND;
                end else if (ny < 11'sd0) begin
                    pos_y_nx = '0;
                    vel_nx   = '0;
                end else begin
                    pos_y_nx = ny[8:0];
                    vel_nx   = vel - 8'(GRAVITY);
                end
            end
            default: state_nx = GROUND;
        endcase
    end

    // pixel colour; 11-bit bounds so pos+size never wraps
    logic [10:0] row_e, col_e, px_e, py_e, dy;
    logic        in_spr;

    always_comb begin
        row_e  = {2'b00, row_addr};
        col_e  = {1'b0, col_addr};
        px_e   = {1'b0, pos_x};
        py_e   = {2'b00, pos_y};
        dy     = row_e - py_e;
        in_spr = (col_e >= px_e) && (col_e < px_e + 11'(SPR_W)) &&
                 (row_e >= py_e) && (row_e < py_e + 11'(SPR_H));
        d_out  = 12'h000;
        if (!rdn) begin
            if (in_spr)
                d_out = (dy < 11'd4) ? HAT_COLOR : BODY_COLOR;
            else if (row_e >= 11'(GROUND_Y))
                d_out = GROUND_COLOR;
            else
                d_out = SKY_COLOR;
        end
    end

endmodule

// File: tb/tb_mario_sprite_gen.sv
// Self-checking bench for mario_sprite_gen: directed scenarios plus
// randomized frames checked against a frame-level physics model.
module tb_mario_sprite_gen;

    logic        vga_clk = 1'b0;
    logic        clrn = 1'b0;
    logic [8:0]  row_addr = '0;
    logic [9:0]  col_addr = '0;
    logic        rdn = 1'b1;
    logic        vs = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [11:0] d_out;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic        airborne;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail = 0;

    // frame-level model
    int mx, my, mv;
    bit mair;
    bit jprev;

    mario_sprite_gen dut (
        .vga_clk(vga_clk), .clrn(clrn), .row_addr(row_addr),
        .col_addr(col_addr), .rdn(rdn), .vs(vs),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .d_out(d_out), .pos_x(pos_x), .pos_y(pos_y),
        .airborne(airborne), .frame_tick(frame_tick)
    );

    always #20 vga_clk = ~vga_clk;

    function automatic int exp_pix(int row, int col, bit rd, int px, int py);
        if (rd) return 'h000;
        if (col >= px && col < px + 16 && row >= py && row < py + 16)
            return (row - py < 4) ? 'h00F : 'hF00;
        return (row >= 400) ? 'h04A : 'hE95;
    endfunction

    task automatic model_reset();
        mx = 32; my = 384; mv = 0; mair = 0; jprev = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit jr);
        int ny;
        if (r && !l) mx = (mx + 2 > 624) ? 624 : mx + 2;
        if (l && !r) mx = (mx - 2 < 0) ? 0 : mx - 2;
        if (!mair) begin
            if (jr) begin my -= 8; mv = 7; mair = 1; end
        end else begin
            ny = my - mv;
            if (ny >= 384) begin my = 384; mv = 0; mair = 0; end
            else if (ny < 0) begin my = 0; mv = 0; end
            else begin my = ny; mv -= 1; end
        end
    endtask

    task automatic apply_reset();
        @(negedge vga_clk);
        clrn = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
        vs = 0; rdn = 1;
        repeat (3) @(negedge vga_clk);
        clrn = 1;
        model_reset();
    endtask

    // one frame of stimulus; returns just after the update edge
    task automatic do_frame(input bit l, input bit r, input bit jlev,
                            input bit pulse);
        bit jr;
        @(negedge vga_clk);
        jr = !jprev && jlev;
        btn_left = l; btn_right = r; btn_jump = jlev; vs = 0;
        repeat (4) @(negedge vga_clk);
        if (pulse && !jlev) begin
            btn_jump = 1;
            repeat (3) @(negedge vga_clk);
            btn_jump = 0;
            jr = 1;
            repeat (3) @(negedge vga_clk);
        end
        jprev = jlev;
        vs = 1;
        model_step(l, r, jr);
        @(posedge vga_clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge vga_clk); #1;
        n_checks += 4;
        if (pos_x !== 10'd32) begin n_fail++;
            $display("FAIL reset_pos_x got %0d want 32", pos_x); end
        if (pos_y !== 9'd384) begin n_fail++;
            $display("FAIL reset_pos_y got %0d want 384", pos_y); end
        if (airborne !== 1'b0) begin n_fail++;
            $display("FAIL reset_airborne got %b want 0", airborne); end
        if (frame_tick !== 1'b0) begin n_fail++;
            $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
    endtask

    task automatic test_pixels();
        int rows[11] = '{390, 386, 450, 100, 390, 390, 390, 383, 384, 387, 388};
        int cols[11] = '{40, 40, 0, 300, 40, 31, 48, 40, 32, 47, 47};
        bit rds[11]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        int want[4]  = '{'hF00, 'h00F, 'h04A, 'hE95};
        int e;
        for (int i = 0; i < 11; i++) begin
            @(negedge vga_clk);
            row_addr = 9'(rows[i]); col_addr = 10'(cols[i]); rdn = rds[i];
            #1;
            e = (i < 4) ? want[i] : exp_pix(rows[i], cols[i], rds[i], 32, 384);
            n_checks++;
            if (d_out !== 12'(e)) begin n_fail++;
                $display("FAIL pixel_%0d r%0d c%0d rdn%b got %h want %h",
                         i, rows[i], cols[i], rds[i], d_out, 12'(e)); end
        end
        rdn = 1;
    endtask

    task automatic test_move_right();
        int want[3] = '{34, 36, 38};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_frame(0, 1, 0, 0);
            n_checks += 2;
            if (pos_x !== 10'(want[i])) begin n_fail++;
                $display("FAIL right_step%0d got %0d want %0d", i, pos_x, want[i]); end
            if (frame_tick !== 1'b1) begin n_fail++;
                $display("FAIL right_tick%0d got %b want 1", i, frame_tick); end
            @(posedge vga_clk); #1;
            n_checks++;
            if (frame_tick !== 1'b0) begin n_fail++;
                $display("FAIL right_tick_low%0d got %b want 0", i, frame_tick); end
        end
        while (mx < 622) do_frame(0, 1, 0, 0);
        n_checks++;
        if (pos_x !== 10'd622) begin n_fail++;
            $display("FAIL right_622 got %0d want 622", pos_x); end
        for (int i = 0; i < 3; i++) begin
            do_frame(0, 1, 0, 0);
            n_checks++;
            if (pos_x !== 10'd624) begin n_fail++;
                $display("FAIL right_sat%0d got %0d want 624", i, pos_x); end
        end
    endtask

    task automatic test_move_left();
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            do_frame(1, 0, 0, 0);
            n_checks++;
            if (pos_x !== 10'(mx)) begin n_fail++;
                $display("FAIL left_frame%0d got %0d want %0d", i, pos_x, mx); end
            if (i == 16 || i == 20) begin
                n_checks++;
                if (pos_x !== 10'd0) begin n_fail++;
                    $display("FAIL left_zero%0d got %0d want 0", i, pos_x); end
            end
        end
        for (int i = 0; i < 4; i++) do_frame(0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            do_frame(1, 1, 0, 0);
            n_checks++;
            if (pos_x !== 10'd8) begin n_fail++;
                $display("FAIL both_hold%0d got %0d want 8", i, pos_x); end
        end
    endtask

    task automatic test_jump();
        int ys[17] = '{376, 369, 363, 358, 354, 351, 349, 348, 348,
                       349, 351, 354, 358, 363, 369, 376, 384};
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            do_frame(0, 0, 0, i == 0);
            n_checks += 2;
            if (pos_y !== 9'(ys[i])) begin n_fail++;
                $display("FAIL jump_y%0d got %0d want %0d", i, pos_y, ys[i]); end
            if (airborne !== (i < 16)) begin n_fail++;
                $display("FAIL jump_air%0d got %b want %b", i, airborne, i < 16); end
        end
    endtask

    task automatic test_no_rejump();
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            do_frame(0, 0, (i >= 13 && i < 22), (i == 0 || i == 2));
            n_checks += 2;
            if (pos_y !== 9'(my)) begin n_fail++;
                $display("FAIL norejump_y%0d got %0d want %0d", i, pos_y, my); end
            if (airborne !== mair) begin n_fail++;
                $display("FAIL norejump_air%0d got %b want %b", i, airborne, mair); end
        end
        n_checks++;
        if (pos_y !== 9'd384) begin n_fail++;
            $display("FAIL norejump_final got %0d want 384", pos_y); end
    endtask

    task automatic test_reset_mid_jump();
        apply_reset();
        for (int i = 0; i < 6; i++) do_frame(0, 1, 0, i == 0);
        n_checks += 2;
        if (pos_y !== 9'd351) begin n_fail++;
            $display("FAIL midjump_y got %0d want 351", pos_y); end
        if (pos_x !== 10'd44) begin n_fail++;
            $display("FAIL midjump_x got %0d want 44", pos_x); end
        @(negedge vga_clk);
        clrn = 0; btn_right = 0; vs = 0;
        @(posedge vga_clk); #1;
        n_checks += 4;
        if (pos_y !== 9'd384) begin n_fail++;
            $display("FAIL midreset_y got %0d want 384", pos_y); end
        if (pos_x !== 10'd32) begin n_fail++;
            $display("FAIL midreset_x got %0d want 32", pos_x); end
        if (airborne !== 1'b0) begin n_fail++;
            $display("FAIL midreset_air got %b want 0", airborne); end
        if (frame_tick !== 1'b0) begin n_fail++;
            $display("FAIL midreset_tick got %b want 0", frame_tick); end
        @(negedge vga_clk);
        clrn = 1;
        model_reset();
    endtask

    task automatic test_random();
        int row, col, e;
        bit l, r, jl, p, rd;
        apply_reset();
        for (int f = 0; f < 80; f++) begin
            l  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            jl = ($urandom_range(0, 7) == 0);
            p  = ($urandom_range(0, 5) == 0);
            do_frame(l, r, jl, p);
            n_checks += 4;
            if (pos_x !== 10'(mx)) begin n_fail++;
                $display("FAIL rand_x f%0d got %0d want %0d", f, pos_x, mx); end
            if (pos_y !== 9'(my)) begin n_fail++;
                $display("FAIL rand_y f%0d got %0d want %0d", f, pos_y, my); end
            if (airborne !== mair) begin n_fail++;
                $display("FAIL rand_air f%0d got %b want %b", f, airborne, mair); end
            if (frame_tick !== 1'b1) begin n_fail++;
                $display("FAIL rand_tick f%0d got %b want 1", f, frame_tick); end
            for (int k = 0; k < 4; k++) begin
                col = mx + $urandom_range(0, 20) - 2;
                row = my + $urandom_range(0, 20) - 2;
                if (k == 3) begin
                    col = $urandom_range(0, 639);
                    row = $urandom_range(0, 479);
                end
                if (col < 0) col = 0;
                if (col > 639) col = 639;
                if (row < 0) row = 0;
                if (row > 479) row = 479;
                rd = ($urandom_range(0, 4) == 0);
                @(negedge vga_clk);
                row_addr = 9'(row); col_addr = 10'(col); rdn = rd;
                #1;
                e = exp_pix(row, col, rd, mx, my);
                n_checks++;
                if (d_out !== 12'(e)) begin n_fail++;
                    $display("FAIL rand_pix f%0d r%0d c%0d rdn%b got %h want %h",
                             f, row, col, rd, d_out, 12'(e)); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pixels();
        test_move_right();
        test_move_left();
        test_jump();
        test_no_rejump();
        test_reset_mid_jump();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
